dcm_multi_controller: RTL

Parametrised dynamic-reconfiguration controller for up to NUM_DCM Spartan-6 DCM_CLKGEN instances driving the hashing cores. It accepts clock-change commands on a valid/ready interface from the command decoder and clamps the requested multiplier. It then serialises LoadD / LoadM / GO sequences onto each selected DCM's PROGEN/PROGDATA and waits for PROGDONE. Broadcast commands reprogram every DCM sequentially; per-channel status is reported back.

---
 rtl/dcm_multi_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dcm_multi_controller.sv
// dcm_multi_controller: serialises LoadD/LoadM/GO reprogramming onto NUM_DCM DCM_CLKGEN channels
// clk, rst_n          : system clock (also PROGCLK), asynchronous active-low reset
// cmd_*               : valid/ready clock-change command (channel, broadcast, M, D)
// dcm_prog_en/data    : per-channel PROGEN/PROGDATA; dcm_prog_done : per-channel PROGDONE
// cur_mult            : last programmed M per channel, channel i at [8i+7:8i]
// err_timeout         : sticky PROGDONE timeout per channel (needs DCM_PROGDONE_TIMEOUT_EN)
// busy, done_pulse    : sequence in progress, whole-command completion strobe
module dcm_multi_controller #(
  parameter int NUM_DCM = 2,
  parameter int INITIAL_MULTIPLIER = 16,
  parameter int DEFAULT_DIVIDER = 8,
  parameter int MIN_MULTIPLIER = 2,
  parameter int MAX_MULTIPLIER = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W = NUM_DCM > 1 ? $clog2(NUM_DCM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CH_W-1:0]      cmd_sel,
  input  logic                 cmd_broadcast,
  input  logic [7:0]           cmd_mult,
  input  logic [7:0]           cmd_div,
  output logic [NUM_DCM-1:0]   dcm_prog_en,
  output logic [NUM_DCM-1:0]   dcm_prog_data,
  input  logic [NUM_DCM-1:0]   dcm_prog_done,
  output logic [8*NUM_DCM-1:0] cur_mult,
  output logic [NUM_DCM-1:0]   err_timeout,
  output logic                 busy,
  output logic                 done_pulse
);
`ifdef DCM_PROGDONE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE} state_t;
  state_t st, st_n;
  logic [15:0] cnt, cnt_n;
  logic [CH_W-1:0] ch, ch_n;
  logic [NUM_DCM-1:0] pend, pend_n, tgt, cand, err;
  logic [7:0] m_q, d_q, m_n, d_n, mc, dc, dm1, mm1;
  logic [7:0] cur [NUM_DCM];
  logic ok, tmo, fin, done_n;
  logic [1:0] bits_n;
  function automatic logic [CH_W-1:0] first(input logic [NUM_DCM-1:0] v);
    first = '0;
    for (int i = NUM_DCM - 1; i >= 0; i--) if (v[i]) first = CH_W'(i);
  endfunction
  // a channel already at the requested M with the default D needs no reprogramming
  always_comb begin
    mc = 32'(cmd_mult) < MIN_MULTIPLIER ? 8'(MIN_MULTIPLIER) :
         32'(cmd_mult) > MAX_MULTIPLIER ? 8'(MAX_MULTIPLIER) : cmd_mult;
    dc = cmd_div == 8'd0 ? 8'(DEFAULT_DIVIDER) : cmd_div;
    tgt = cmd_broadcast ? '1 : 32'(cmd_sel) < NUM_DCM ? NUM_DCM'(1) << cmd_sel : '0;
    cand = tgt;
    for (int i = 0; i < NUM_DCM; i++) cand[i] = tgt[i] & ~(mc == cur[i] && dc == 8'(DEFAULT_DIVIDER));
  end
  assign ok = st == WAIT_DONE && dcm_prog_done[ch];
  assign tmo = TO_EN && st == WAIT_DONE && !dcm_prog_done[ch] && cnt == 16'(TIMEOUT_CYCLES - 1);
  assign fin = ok | tmo;
  always_comb begin
    st_n = st;
    cnt_n = cnt + 16'd1;
    ch_n = ch;
    pend_n = pend;
    m_n = m_q;
    d_n = d_q;
    done_n = 1'b0;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid) begin
          m_n = mc;
          d_n = dc;
          done_n = ~|cand;
          if (|cand) begin
            st_n = LOAD_D;
            ch_n = first(cand);
            pend_n = cand & ~(NUM_DCM'(1) << first(cand));
          end
        end
      end
      LOAD_D: if (cnt == 16'd9) begin st_n = GAP1; cnt_n = '0; end
      GAP1: if (cnt == 16'd2) begin st_n = LOAD_M; cnt_n = '0; end
      LOAD_M: if (cnt == 16'd9) begin st_n = GAP2; cnt_n = '0; end
      GAP2: if (cnt == 16'd1) begin st_n = GO; cnt_n = '0; end
      GO: begin st_n = WAIT_DONE; cnt_n = '0; end
      WAIT_DONE: if (fin) begin
        cnt_n = '0;
        st_n = |pend ? LOAD_D : IDLE;
        ch_n = |pend ? first(pend) : ch;
        pend_n = pend & ~(NUM_DCM'(1) << first(pend));
        done_n = ~|pend;
      end
      default: st_n = IDLE;
    endcase
  end
  // outputs are registered from the state being entered so PROGEN/PROGDATA are glitch-free
  assign dm1 = d_n - 8'd1;
  assign mm1 = m_n - 8'd1;
  assign bits_n = st_n == LOAD_D ? (cnt_n == 16'd0 ? 2'b11 : cnt_n == 16'd1 ? 2'b10 : {1'b1, dm1[3'(cnt_n - 16'd2)]}) :
                  st_n == LOAD_M ? (cnt_n < 16'd2 ? 2'b11 : {1'b1, mm1[3'(cnt_n - 16'd2)]}) :
                  st_n == GO ? 2'b10 : 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      ch <= '0;
      pend <= '0;
      m_q <= '0;
      d_q <= '0;
      dcm_prog_en <= '0;
      dcm_prog_data <= '0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done_pulse <= 1'b0;
      err <= '0;
      for (int i = 0; i < NUM_DCM; i++) cur[i] <= 8'(INITIAL_MULTIPLIER);
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ch <= ch_n;
      pend <= pend_n;
      m_q <= m_n;
      d_q <= d_n;
      dcm_prog_en <= NUM_DCM'(bits_n[1]) << ch_n;
      dcm_prog_data <= NUM_DCM'(bits_n[0]) << ch_n;
      cmd_ready <= st_n == IDLE;
      busy <= st_n != IDLE;
      done_pulse <= done_n;
      if (ok) begin
        cur[ch] <= m_q;
        err[ch] <= 1'b0;
      end
      if (tmo) err[ch] <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_DCM; g++) assign cur_mult[8*g +: 8] = cur[g];
  assign err_timeout = TO_EN ? err : '0;
endmodule
